// File: rtl/stream_msg_gen.sv
// Val/rdy message source: takes one (base, stride, count) command and emits
// base, base+stride, ... for count messages, flagging the final one with last.
module stream_msg_gen #(
  parameter int p_msg_nbits = 32,
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [p_msg_nbits-1:0] cfg_base,
  input  logic [p_msg_nbits-1:0] cfg_stride,
  input  logic [p_cnt_nbits-1:0] cfg_count,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic                   ostream_last,
  output logic                   busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [p_cnt_nbits-1:0] CntOne = p_cnt_nbits'(1);
  localparam logic [p_cnt_nbits-1:0] CntTwo = p_cnt_nbits'(2);

  state_t                 state_q;
  logic [p_msg_nbits-1:0] cur_q, cur_d;
  logic [p_msg_nbits-1:0] step_q;
  logic [p_cnt_nbits-1:0] rem_q, rem_d;
  logic                   rdy_q, val_q, last_q, busy_q;
  logic                   cfgFire, outFire;

  assign cfgFire = cfg_val && rdy_q;
  assign outFire = val_q && ostream_rdy;

  always_comb begin
    cur_d = cur_q + step_q;
    rem_d = rem_q - CntOne;
  end

  // Every output is a flop; each transition sets the flags the next state needs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (cfgFire && (cfg_count != '0)) begin
            state_q <= SEND;
            cur_q   <= cfg_base;
            step_q  <= cfg_stride;
            rem_q   <= cfg_count;
            rdy_q   <= 1'b0;
            val_q   <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= (cfg_count == CntOne);
          end
        end
        SEND: begin
          if (outFire) begin
            cur_q <= cur_d;
            rem_q <= rem_d;
            if (rem_q == CntOne) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
              val_q   <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              last_q <= (rem_q == CntTwo);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_rdy      = rdy_q;
  assign ostream_val  = val_q;
  assign ostream_msg  = cur_q;
  assign ostream_last = last_q;
  assign busy         = busy_q;

endmodule
